// File: rtl/v_mem_wb_if.sv
// Bundle of the issue, vector-memory request/response and vreg write signals
// around the vector memory/writeback stage.
`timescale 1ns/1ps
interface v_mem_wb_if #(
  parameter int VMEM_DW = 512,
  parameter int VMEM_AW = 64,
  parameter int VREG_DW = 512,
  parameter int VREG_AW = 5
) ();
  logic               issue_valid_i;
  logic               issue_ready_o;
  logic               vmem_ren_i;
  logic               vmem_wen_i;
  logic [VMEM_AW-1:0] vmem_addr_i;
  logic [VMEM_DW-1:0] vmem_din_i;
  logic               vid_wb_en_i;
  logic               vid_wb_sel_i;
  logic [VREG_AW-1:0] vid_wb_addr_i;
  logic [VREG_DW-1:0] valu_result_i;
  logic               mem_req_valid_o;
  logic               mem_req_we_o;
  logic [VMEM_AW-1:0] mem_req_addr_o;
  logic [VMEM_DW-1:0] mem_req_wdata_o;
  logic               mem_req_ready_i;
  logic               mem_rsp_valid_i;
  logic [VMEM_DW-1:0] mem_rsp_rdata_i;
  logic               vreg_wen_o;
  logic [VREG_AW-1:0] vreg_waddr_o;
  logic [VREG_DW-1:0] vreg_wdata_o;
  logic               busy_o;

  modport slave (
    input  issue_valid_i, vmem_ren_i, vmem_wen_i, vmem_addr_i, vmem_din_i,
           vid_wb_en_i, vid_wb_sel_i, vid_wb_addr_i, valu_result_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i,
    output issue_ready_o, mem_req_valid_o, mem_req_we_o, mem_req_addr_o,
           mem_req_wdata_o, vreg_wen_o, vreg_waddr_o, vreg_wdata_o, busy_o
  );

  modport master (
    output issue_valid_i, vmem_ren_i, vmem_wen_i, vmem_addr_i, vmem_din_i,
           vid_wb_en_i, vid_wb_sel_i, vid_wb_addr_i, valu_result_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i,
    input  issue_ready_o, mem_req_valid_o, mem_req_we_o, mem_req_addr_o,
           mem_req_wdata_o, vreg_wen_o, vreg_waddr_o, vreg_wdata_o, busy_o
  );
endinterface

// File: rtl/v_mem_wb.sv
// Vector memory/writeback stage: ALU results go straight to the vreg write port,
// vle/vse are serialised through an IDLE/REQ/WAIT FSM onto the memory channel.
`timescale 1ns/1ps
module v_mem_wb #(
  parameter int VMEM_DW = 512,
  parameter int VMEM_AW = 64,
  parameter int VREG_DW = 512,
  parameter int VREG_AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  v_mem_wb_if.slave     bus
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_we;
  logic [VMEM_AW-1:0] r_addr;
  logic [VMEM_DW-1:0] r_wdata;
  logic [VREG_AW-1:0] r_vd;
  logic               r_vreg_wen;
  logic [VREG_AW-1:0] r_vreg_waddr;
  logic [VREG_DW-1:0] r_vreg_wdata;

  logic               w_accept;
  logic               w_is_load;
  logic               w_is_store;
  logic               w_is_alu;
  logic               w_req_done;
  logic               w_rsp_take;
  logic               w_wb_fire;
  logic [VREG_AW-1:0] w_wb_addr;
  logic [VREG_DW-1:0] w_wb_data;

  // Load has priority over store when both flags are set.
  assign w_accept   = bus.issue_valid_i && (r_state == ST_IDLE);
  assign w_is_load  = w_accept && bus.vmem_ren_i;
  assign w_is_store = w_accept && !bus.vmem_ren_i && bus.vmem_wen_i;
  assign w_is_alu   = w_accept && !bus.vmem_ren_i && !bus.vmem_wen_i &&
                      bus.vid_wb_en_i && !bus.vid_wb_sel_i;
  assign w_req_done = (r_state == ST_REQ) && bus.mem_req_ready_i;
  assign w_rsp_take = (r_state == ST_WAIT) && bus.mem_rsp_valid_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_is_load || w_is_store) w_state_next = ST_REQ;
      ST_REQ:  if (w_req_done) w_state_next = r_we ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (w_rsp_take) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Writeback source select; ALU and load writebacks live in different states.
  always_comb begin
    w_wb_fire = 1'b0;
    w_wb_addr = r_vreg_waddr;
    w_wb_data = r_vreg_wdata;
    if (w_is_alu) begin
      w_wb_fire = 1'b1;
      w_wb_addr = bus.vid_wb_addr_i;
      w_wb_data = bus.valu_result_i;
    end else if (w_rsp_take) begin
      w_wb_fire = 1'b1;
      w_wb_addr = r_vd;
      w_wb_data = bus.mem_rsp_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_vd         <= '0;
      r_vreg_wen   <= 1'b0;
      r_vreg_waddr <= '0;
      r_vreg_wdata <= '0;
    end else begin
      r_vreg_wen   <= w_wb_fire;
      r_vreg_waddr <= w_wb_addr;
      r_vreg_wdata <= w_wb_data;
      if (w_is_load) begin
        r_we    <= 1'b0;
        r_addr  <= bus.vmem_addr_i;
        r_wdata <= '0;
        r_vd    <= bus.vid_wb_addr_i;
      end else if (w_is_store) begin
        r_we    <= 1'b1;
        r_addr  <= bus.vmem_addr_i;
        r_wdata <= bus.vmem_din_i;
      end
    end
  end

  assign bus.issue_ready_o   = (r_state == ST_IDLE);
  assign bus.busy_o          = (r_state != ST_IDLE);
  assign bus.mem_req_valid_o = (r_state == ST_REQ);
  assign bus.mem_req_we_o    = r_we;
  assign bus.mem_req_addr_o  = r_addr;
  assign bus.mem_req_wdata_o = r_wdata;
  assign bus.vreg_wen_o      = r_vreg_wen;
  assign bus.vreg_waddr_o    = r_vreg_waddr;
  assign bus.vreg_wdata_o    = r_vreg_wdata;
endmodule

// File: tb/tb_v_mem_wb.sv
// Bench for v_mem_wb: ALU vector table plus hand-written load/store/reset
// sequences, with queue scoreboards for memory requests and vreg writes.
`timescale 1ns/1ps
module tb_v_mem_wb;
  localparam int DW = 512;
  localparam int AW = 64;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  v_mem_wb_if #(.VMEM_DW(DW), .VMEM_AW(AW), .VREG_DW(DW), .VREG_AW(RW)) bus ();
  v_mem_wb #(.VMEM_DW(DW), .VMEM_AW(AW), .VREG_DW(DW), .VREG_AW(RW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { logic [RW-1:0] addr; logic [DW-1:0] data; } wb_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
  typedef struct {
    logic          ren, wen, wb_en, wb_sel;
    logic [RW-1:0] vd;
    logic [DW-1:0] res;
    logic          exp_wb;
  } vec_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clr_issue();
    bus.issue_valid_i = 1'b0;
    bus.vmem_ren_i    = 1'b0;
    bus.vmem_wen_i    = 1'b0;
    bus.vmem_addr_i   = '0;
    bus.vmem_din_i    = '0;
    bus.vid_wb_en_i   = 1'b0;
    bus.vid_wb_sel_i  = 1'b0;
    bus.vid_wb_addr_i = '0;
    bus.valu_result_i = '0;
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: request fields are compared every valid cycle so any
  // instability before the handshake is caught.
  always @(negedge clk) begin
    if (rst && bus.vreg_wen_o) begin
      if (wb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_wb: got vd=%0d want no write", bus.vreg_waddr_o);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        check("wb_addr", DW'(bus.vreg_waddr_o), DW'(e.addr));
        check("wb_data", bus.vreg_wdata_o, e.data);
        $display("wb vd=%0d data[31:0]=%h", bus.vreg_waddr_o, bus.vreg_wdata_o[31:0]);
      end
    end
    if (rst && bus.mem_req_valid_o) begin
      if (req_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_req: got addr=%h want no request", bus.mem_req_addr_o);
      end else begin
        check("req_we", DW'(bus.mem_req_we_o), DW'(req_q[0].we));
        check("req_addr", DW'(bus.mem_req_addr_o), DW'(req_q[0].addr));
        check("req_wdata", bus.mem_req_wdata_o, req_q[0].data);
        if (bus.mem_req_ready_i) begin
          void'(req_q.pop_front());
          $display("req we=%0b addr=%h", bus.mem_req_we_o, bus.mem_req_addr_o);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[7];
  logic [DW-1:0] a5;

  initial begin
    clr_issue();
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_rdata_i = '0;
    a5 = {16{32'h000000A5}};
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd1,  a5, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd2,  a5, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd3,  a5, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd4,  a5, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd5,  ~a5, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd6,  ~a5, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd31, {16{32'h5A5A0F0F}}, 1'b1};

    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_req_valid", DW'(bus.mem_req_valid_o), DW'(1'b0));
    check("rst_req_we", DW'(bus.mem_req_we_o), DW'(1'b0));
    check("rst_req_addr", DW'(bus.mem_req_addr_o), '0);
    check("rst_req_wdata", bus.mem_req_wdata_o, '0);
    check("rst_vreg_wen", DW'(bus.vreg_wen_o), DW'(1'b0));
    check("rst_vreg_waddr", DW'(bus.vreg_waddr_o), '0);
    check("rst_vreg_wdata", bus.vreg_wdata_o, '0);
    check("rst_busy", DW'(bus.busy_o), DW'(1'b0));
    check("rst_ready", DW'(bus.issue_ready_o), DW'(1'b1));

    // ALU / NOP table, one instruction per cycle
    for (int i = 0; i < 7; i++) begin
      drive();
      bus.issue_valid_i = 1'b1;
      bus.vmem_ren_i    = tbl[i].ren;
      bus.vmem_wen_i    = tbl[i].wen;
      bus.vid_wb_en_i   = tbl[i].wb_en;
      bus.vid_wb_sel_i  = tbl[i].wb_sel;
      bus.vid_wb_addr_i = tbl[i].vd;
      bus.valu_result_i = tbl[i].res;
      if (tbl[i].exp_wb) wb_q.push_back('{tbl[i].vd, tbl[i].res});
      @(negedge clk);
      check("alu_ready", DW'(bus.issue_ready_o), DW'(1'b1));
      if (i > 0) check("alu_wen", DW'(bus.vreg_wen_o), DW'(tbl[i-1].exp_wb));
    end
    drive();
    clr_issue();
    @(negedge clk);
    check("alu_wen_last", DW'(bus.vreg_wen_o), DW'(tbl[6].exp_wb));

    // Load: ready held low 2 cycles, spurious response in REQ ignored
    drive();
    bus.issue_valid_i = 1'b1;
    bus.vmem_ren_i    = 1'b1;
    bus.vmem_addr_i   = 64'h1000;
    bus.vmem_din_i    = {16{32'hBAD0BAD0}};
    bus.vid_wb_en_i   = 1'b1;
    bus.vid_wb_sel_i  = 1'b1;
    bus.vid_wb_addr_i = 5'd7;
    req_q.push_back('{1'b0, 64'h1000, '0});
    wb_q.push_back('{5'd7, 512'h1234});
    drive();
    clr_issue();
    bus.vmem_addr_i     = 64'hDEAD;
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_rdata_i = 512'hBEEF;
    @(negedge clk);
    check("ld_req_valid", DW'(bus.mem_req_valid_o), DW'(1'b1));
    check("ld_busy", DW'(bus.busy_o), DW'(1'b1));
    check("ld_ready_low", DW'(bus.issue_ready_o), DW'(1'b0));
    drive();
    bus.mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    check("ld_req_held", DW'(bus.mem_req_valid_o), DW'(1'b1));
    drive();
    bus.mem_req_ready_i = 1'b1;
    drive();
    bus.mem_req_ready_i = 1'b0;
    @(negedge clk);
    check("ld_wait_valid", DW'(bus.mem_req_valid_o), DW'(1'b0));
    check("ld_wait_busy", DW'(bus.busy_o), DW'(1'b1));
    drive();
    drive();
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_rdata_i = 512'h1234;
    @(negedge clk);
    check("ld_wen_early", DW'(bus.vreg_wen_o), DW'(1'b0));
    drive();
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_rdata_i = 512'h9999;
    @(negedge clk);
    check("ld_wen", DW'(bus.vreg_wen_o), DW'(1'b1));
    check("ld_waddr", DW'(bus.vreg_waddr_o), DW'(5'd7));
    check("ld_wdata", bus.vreg_wdata_o, 512'h1234);
    check("ld_ready_back", DW'(bus.issue_ready_o), DW'(1'b1));
    drive();
    @(negedge clk);
    check("ld_wen_pulse", DW'(bus.vreg_wen_o), DW'(1'b0));
    check("ld_waddr_hold", DW'(bus.vreg_waddr_o), DW'(5'd7));

    // Store with immediate ready, then a spurious response
    drive();
    bus.issue_valid_i   = 1'b1;
    bus.vmem_wen_i      = 1'b1;
    bus.vmem_addr_i     = 64'h2040;
    bus.vmem_din_i      = {DW{1'b1}};
    bus.mem_req_ready_i = 1'b1;
    req_q.push_back('{1'b1, 64'h2040, {DW{1'b1}}});
    drive();
    clr_issue();
    @(negedge clk);
    check("st_req_valid", DW'(bus.mem_req_valid_o), DW'(1'b1));
    check("st_we", DW'(bus.mem_req_we_o), DW'(1'b1));
    check("st_ready_low", DW'(bus.issue_ready_o), DW'(1'b0));
    drive();
    bus.mem_req_ready_i = 1'b0;
    @(negedge clk);
    check("st_req_done", DW'(bus.mem_req_valid_o), DW'(1'b0));
    check("st_ready_back", DW'(bus.issue_ready_o), DW'(1'b1));
    check("st_no_wb", DW'(bus.vreg_wen_o), DW'(1'b0));
    drive();
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_rdata_i = 512'h7777;
    drive();
    bus.mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    check("st_spurious_rsp", DW'(bus.vreg_wen_o), DW'(1'b0));
    check("st_idle", DW'(bus.busy_o), DW'(1'b0));

    // Reset while waiting for load data
    drive();
    bus.issue_valid_i   = 1'b1;
    bus.vmem_ren_i      = 1'b1;
    bus.vmem_addr_i     = 64'h3000;
    bus.vid_wb_addr_i   = 5'd9;
    bus.mem_req_ready_i = 1'b1;
    req_q.push_back('{1'b0, 64'h3000, '0});
    drive();
    clr_issue();
    drive();
    bus.mem_req_ready_i = 1'b0;
    @(negedge clk);
    check("rm_wait_busy", DW'(bus.busy_o), DW'(1'b1));
    #1 rst = 1'b0;
    #1;
    check("rm_busy", DW'(bus.busy_o), DW'(1'b0));
    check("rm_ready", DW'(bus.issue_ready_o), DW'(1'b1));
    check("rm_addr_clr", DW'(bus.mem_req_addr_o), '0);
    drive();
    rst = 1'b1;
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_rdata_i = 512'h5555;
    drive();
    bus.mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    check("rm_no_wb", DW'(bus.vreg_wen_o), DW'(1'b0));
    check("rm_idle", DW'(bus.busy_o), DW'(1'b0));

    // ren = wen = 1 behaves as a load, minimum latency
    drive();
    bus.issue_valid_i   = 1'b1;
    bus.vmem_ren_i      = 1'b1;
    bus.vmem_wen_i      = 1'b1;
    bus.vmem_addr_i     = 64'h4000;
    bus.vmem_din_i      = 512'hDEAD;
    bus.vid_wb_en_i     = 1'b1;
    bus.vid_wb_sel_i    = 1'b1;
    bus.vid_wb_addr_i   = 5'd3;
    bus.mem_req_ready_i = 1'b1;
    req_q.push_back('{1'b0, 64'h4000, '0});
    wb_q.push_back('{5'd3, 512'hCAFE});
    drive();
    clr_issue();
    @(negedge clk);
    check("il_we", DW'(bus.mem_req_we_o), DW'(1'b0));
    check("il_wdata", bus.mem_req_wdata_o, '0);
    drive();
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_rdata_i = 512'hCAFE;
    drive();
    bus.mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    check("il_wen", DW'(bus.vreg_wen_o), DW'(1'b1));
    check("il_waddr", DW'(bus.vreg_waddr_o), DW'(5'd3));

    repeat (3) drive();
    @(negedge clk);
    check("wb_q_empty", DW'(wb_q.size()), '0);
    check("req_q_empty", DW'(req_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/v_mem_wb.md
# v_mem_wb

Vector memory/writeback stage directly downstream of the vector instruction decoder and vector ALU. It accepts one decoded vector instruction per handshake and routes it. ALU results go straight to the vector register file write port. `vle`/`vse` requests are issued to vector memory over a valid/ready request channel, and load data is returned on a response channel and written back. A simple FSM serialises memory operations; the decoder stage stalls on `issue_ready_o`.

## Interface
- `VMEM_DW`, 512, vector memory data width
- `VMEM_AW`, 64, vector memory address width
- `VREG_DW`, 512, vector register data width
- `VREG_AW`, 5, vector register address width

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `issue_valid_i` in 1: decoded instruction present.
- `issue_ready_o` out 1: stage can accept an instruction.
- `vmem_ren_i` in 1: instruction is a vector load.
- `vmem_wen_i` in 1: instruction is a vector store.
- `vmem_addr_i` in `VMEM_AW`: memory address (rs1 value).
- `vmem_din_i` in `VMEM_DW`: store data.
- `vid_wb_en_i` in 1: instruction writes a vector register.
- `vid_wb_sel_i` in 1: writeback source; 0 = ALU, 1 = memory.
- `vid_wb_addr_i` in `VREG_AW`: destination register `vd`.
- `valu_result_i` in `VREG_DW`: ALU result for this instruction.
- `mem_req_valid_o` out 1: memory request valid.
- `mem_req_we_o` out 1: request is a write.
- `mem_req_addr_o` out `VMEM_AW`: request address.
- `mem_req_wdata_o` out `VMEM_DW`: write data.
- `mem_req_ready_i` in 1: memory accepts the request.
- `mem_rsp_valid_i` in 1: load data valid.
- `mem_rsp_rdata_i` in `VMEM_DW`: load data.
- `vreg_wen_o` out 1: vector register write enable.
- `vreg_waddr_o` out `VREG_AW`: write address.
- `vreg_wdata_o` out `VREG_DW`: write data.
- `busy_o` out 1: FSM not in IDLE.

## Operation
- **States:** IDLE, REQ, WAIT.
- **Ready:** `issue_ready_o` = (state == IDLE), purely combinational. An instruction is accepted on a clock edge where `issue_valid_i` and `issue_ready_o` are both 1.
- **Classification at accept:**
  - `vmem_ren_i` = 1: load. Latch addr and `vd`, go to REQ with `we` = 0.
  - else `vmem_wen_i` = 1: store. Latch addr and din, go to REQ with `we` = 1.
  - else `vid_wb_en_i` = 1 and `vid_wb_sel_i` = 0: ALU op. Register {1, `vid_wb_addr_i`, `valu_result_i`} onto the vreg write port. Stay in IDLE.
  - else: NOP. Accepted, no effect.
  - If `ren` and `wen` are both 1, the load wins and the store is discarded.
- **REQ:**
  - `mem_req_valid_o` = 1. `mem_req_we_o`, `mem_req_addr_o` and `mem_req_wdata_o` are held stable from the latched values until `mem_req_ready_i` is sampled 1.
  - On handshake, a store goes to IDLE and a load goes to WAIT.
  - Store `wdata` is driven only for stores. During load requests `mem_req_wdata_o` = 0.
- **WAIT:** on `mem_rsp_valid_i` = 1, register {1, latched `vd`, `mem_rsp_rdata_i`} onto the vreg write port and go to IDLE.
- **Ignored inputs:** `mem_rsp_valid_i` is ignored in IDLE and REQ. `mem_req_ready_i` is ignored outside REQ.
- **Write port:** `vreg_wen_o` is a one-cycle pulse. When it is 0, `vreg_waddr_o` and `vreg_wdata_o` hold their last values. Address and data pass through unmodified; no width conversion is done in this stage.
- **Reset:** asserting `rst` at any point aborts any in-flight request. The state returns to IDLE, the latched request is cleared, and the pending writeback is dropped.

## Timing
- **Reset values:** `mem_req_valid_o` = 0, `mem_req_we_o` = 0, `mem_req_addr_o` = 0, `mem_req_wdata_o` = 0, `vreg_wen_o` = 0, `vreg_waddr_o` = 0, `vreg_wdata_o` = 0, `busy_o` = 0, `issue_ready_o` = 1.
- **ALU op:** accept at edge N, so `vreg_wen_o` = 1 during cycle N+1. Back-to-back ALU ops sustain one writeback per cycle.
- **Store:** accept at edge N, so `mem_req_valid_o` = 1 from cycle N+1. Handshake at edge M, so `issue_ready_o` = 1 in cycle M+1.
- **Load:**
  - Accept at edge N, request valid from cycle N+1, handshake at edge M.
  - Response sampled at edge K > M, so `vreg_wen_o` = 1 in cycle K+1, with `issue_ready_o` = 1 in the same cycle.
  - Minimum accept-to-writeback latency is 3 cycles.
- **Writeback overlap:** an ALU op accepted in cycle K+1 writes back in K+2, so there is never more than one vreg write per cycle.
- **Outputs:** `busy_o` and all request outputs are registered or purely state-decoded. There is no combinational path from `mem_req_ready_i` to `mem_req_valid_o`.

## Test plan
- **Reset:** hold `rst` = 0 for 3 cycles, then release -> all outputs at reset values, `issue_ready_o` = 1, `busy_o` = 0.
- **ALU stream:** 4 consecutive ALU ops with `vd` = 1..4 and result = 32'hA5 replicated -> `vreg_wen_o` high for 4 consecutive cycles with `waddr` 1, 2, 3, 4, `issue_ready_o` never low.
- **Load:**
  - Stimulus: load with addr = 0x1000, `vd` = 7; `mem_req_ready_i` low 2 cycles then high; response 3 cycles later with `rdata` = 512'h1234.
  - Required: request fields held stable throughout; `vreg_wen_o` = 1 with `waddr` 7 and `wdata` 512'h1234 exactly one cycle after the response.
- **Store:** store with addr = 0x2040, `din` = all-ones, immediate ready -> one request cycle with `we` = 1; no vreg write; `issue_ready_o` = 1 two cycles after accept; a spurious `mem_rsp_valid_i` afterwards is ignored.
- **Reset mid-operation:** load in WAIT, assert `rst` -> IDLE; a later `mem_rsp_valid_i` produces no write.
- **Illegal combination:** instruction with `ren` = `wen` = 1 -> treated as a load (`we` = 0).
